debug_uart_rx: RTL



---
 rtl/debug_uart_rx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/debug_uart_rx.sv
// 8N1 UART receiver for the debug link: 2-flop synchronized RXD, mid-bit sampling,
// one-cycle RI / framing_error strobes toward the command parser.
module debug_uart_rx #(
  parameter int BAUD_PERIOD = 868,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  UART_enable,
  input  logic                  REN,
  input  logic                  RXD,
  output logic [DATA_WIDTH-1:0] SBUF_out,
  output logic                  RI,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BAUD_PERIOD + 1);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      bit_index, idx_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt, sbuf_nxt;
  logic [DATA_WIDTH:0]   shift_in;
  logic                  ri_nxt, fe_nxt;
  logic                  rxd_meta, rxd_s;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_index     <= '0;
      shreg         <= '0;
      SBUF_out      <= '0;
      RI            <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_index     <= idx_nxt;
      shreg         <= shreg_nxt;
      SBUF_out      <= sbuf_nxt;
      RI            <= ri_nxt;
      framing_error <= fe_nxt;
    end
  end

  // LSB arrives first, so each new bit enters at the MSB and shifts right.
  assign shift_in = {rxd_s, shreg};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = bit_index;
    shreg_nxt = shreg;
    sbuf_nxt  = SBUF_out;
    ri_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (REN && !rxd_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rxd_s) begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = shift_in[DATA_WIDTH:1];
          if (bit_index == IDX_LAST) state_nxt = S_STOP;
          else                       idx_nxt   = bit_index + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt = '0;
          if (rxd_s) begin
            sbuf_nxt  = shreg;
            ri_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rxd_s) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Disable wins over any in-flight frame; the partial byte is dropped.
    if (!UART_enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      shreg_nxt = '0;
      sbuf_nxt  = SBUF_out;
      ri_nxt    = 1'b0;
      fe_nxt    = 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
